uart_tx_fifo: RTL

//  Byte FIFO and transmit sequencer placed directly upstream of uart (CLOCK_DIVIDE 2604).

---
 rtl/uart_tx_fifo_if.sv | 17 +
 rtl/uart_tx_fifo.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer-side push/status bundle for uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
) ();
  localparam int ADDR_W = $clog2(DEPTH);

  logic            wr_en;
  logic [7:0]      wr_data;
  logic            flush;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;

  modport master (output wr_en, wr_data, flush, input full, empty, count, overflow);
  modport slave  (input wr_en, wr_data, flush, output full, empty, count, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus transmit sequencer feeding a uart transmit/tx_byte pair.
// Bytes are issued one at a time, paced on uart_is_transmitting.
module uart_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = $clog2(DEPTH),
  parameter int START_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave push_if,
  output logic          tx_error,
  output logic          busy,
  output logic          uart_transmit,
  output logic [7:0]    uart_tx_byte,
  input  logic          uart_is_transmitting
);
  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              full, empty, push, pop, ovf_q;
  logic              transmit_d, error_d;
  logic [7:0]        tx_byte_d;

  // full/empty come from the registered count, so a same-cycle pop never frees a slot
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = push_if.wr_en & ~full & ~push_if.flush;

  assign push_if.full     = full;
  assign push_if.empty    = empty;
  assign push_if.count    = count_q;
  assign push_if.overflow = ovf_q;

  assign busy = (state_q != IDLE) | uart_is_transmitting;

  // Storage write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_if.wr_data;
  end

  // Pointers, occupancy and overflow pulse; flush overrides push and pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= push_if.wr_en & full & ~push_if.flush;
      if (push_if.flush) begin
        rd_ptr_q <= wr_ptr_q;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Sequencer next-state and next registered outputs
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    transmit_d = 1'b0;
    error_d    = 1'b0;
    tx_byte_d  = uart_tx_byte;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !uart_is_transmitting && !push_if.flush) begin
          pop        = 1'b1;
          transmit_d = 1'b1;
          tx_byte_d  = mem[rd_ptr_q];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        // the limit is compared before incrementing, giving the uart
        // START_TIMEOUT+1 looks at is_transmitting before the byte is dropped
        if (uart_is_transmitting) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_W'(START_TIMEOUT)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_is_transmitting) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered uart-side outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= 8'h00;
      tx_error      <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      uart_transmit <= transmit_d;
      uart_tx_byte  <= tx_byte_d;
      tx_error      <= error_d;
    end
  end
endmodule
